// File: rtl/spi_ram_access_ctrl_pkg.sv
// Shared definitions for the SPI-to-RAM access controller: command codes,
// FSM state encoding and grant identifiers.
package spi_ram_access_ctrl_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_SPI_ACC  = 2'b01,
        ST_HOST_ACC = 2'b10,
        ST_RD_RESP  = 2'b11
    } state_t;

    localparam logic GNT_HOST = 1'b0;
    localparam logic GNT_SPI  = 1'b1;

    // Bit 0 of the command distinguishes data commands from address commands.
    function automatic logic is_data_cmd(input logic [1:0] cmd);
        return cmd[0];
    endfunction

endpackage

// File: rtl/spi_ram_access_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter (SPI vs host) with an optional
// fixed-priority override that always favours SPI.
module spi_ram_access_ctrl_rr_arb2
    import spi_ram_access_ctrl_pkg::*;
#(
    parameter int SPI_PRIO = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic req_spi,
    input  logic req_host,
    input  logic take,
    output logic gnt_spi,
    output logic gnt_host
);

    logic last_gnt_r;

    // Grant decision: contention resolved by priority mode or by last winner.
    always_comb begin
        gnt_spi  = 1'b0;
        gnt_host = 1'b0;
        if (req_spi && req_host) begin
            if ((SPI_PRIO != 0) || (last_gnt_r == GNT_HOST)) begin
                gnt_spi = 1'b1;
            end else begin
                gnt_host = 1'b1;
            end
        end else begin
            gnt_spi  = req_spi;
            gnt_host = req_host;
        end
    end

    // Remember the winner of every grant that is actually taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt_r <= GNT_HOST;
        end else if (take && gnt_spi) begin
            last_gnt_r <= GNT_SPI;
        end else if (take && gnt_host) begin
            last_gnt_r <= GNT_HOST;
        end
    end

endmodule

// File: rtl/spi_ram_access_ctrl.sv
// Decodes SPI command words, holds the SPI address registers and one pending
// SPI op, and shares the single RAM port between SPI and the local host.
module spi_ram_access_ctrl
    import spi_ram_access_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int SPI_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [7:0]        host_wdata,
    output logic              host_gnt,
    output logic [7:0]        host_rdata,
    output logic              host_rvalid,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic              err_ovf,
    input  logic              err_clr
);

    state_t            state_r;
    logic [ADDR_W-1:0] wr_addr_r, rd_addr_r, op_addr_r, ram_addr_r;
    logic [7:0]        op_wdata_r, ram_wdata_r, tx_data_r, host_rdata_r;
    logic              spi_pend_r, op_we_r, err_ovf_r, rd_src_spi_r;
    logic              ram_en_r, ram_we_r, host_gnt_r, tx_valid_r, host_rvalid_r;
    logic [1:0]        cmd_s;
    logic [ADDR_W-1:0] payload_addr_s;
    logic              data_cmd_s, ovf_s, gnt_spi_s, gnt_host_s;

    // Command decode; a data command overflows only if the pending op is not being served now.
    always_comb begin
        cmd_s          = rx_data[9:8];
        payload_addr_s = ADDR_W'(rx_data[7:0]);
        data_cmd_s     = rx_valid && is_data_cmd(cmd_s);
        ovf_s          = data_cmd_s && spi_pend_r && (state_r != ST_SPI_ACC);
    end

    spi_ram_access_ctrl_rr_arb2 #(.SPI_PRIO(SPI_PRIO)) u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_spi  (spi_pend_r),
        .req_host (host_req),
        .take     (state_r == ST_IDLE),
        .gnt_spi  (gnt_spi_s),
        .gnt_host (gnt_host_s)
    );

    // Address registers, pending-op capture and sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr_r  <= {ADDR_W{1'b0}};
            rd_addr_r  <= {ADDR_W{1'b0}};
            spi_pend_r <= 1'b0;
            op_we_r    <= 1'b0;
            op_addr_r  <= {ADDR_W{1'b0}};
            op_wdata_r <= 8'h00;
            err_ovf_r  <= 1'b0;
        end else begin
            if (rx_valid && (cmd_s == CMD_WR_ADDR)) begin
                wr_addr_r <= payload_addr_s;
            end
            if (rx_valid && (cmd_s == CMD_RD_ADDR)) begin
                rd_addr_r <= payload_addr_s;
            end
            if (data_cmd_s && !ovf_s) begin
                spi_pend_r <= 1'b1;
                op_we_r    <= (cmd_s == CMD_WR_DATA);
                op_addr_r  <= (cmd_s == CMD_WR_DATA) ? wr_addr_r : rd_addr_r;
                op_wdata_r <= rx_data[7:0];
            end else if (state_r == ST_SPI_ACC) begin
                spi_pend_r <= 1'b0;
            end
            if (ovf_s) begin
                err_ovf_r <= 1'b1;
            end else if (err_clr) begin
                err_ovf_r <= 1'b0;
            end
        end
    end

    // Access FSM; RAM and strobe outputs are registered alongside the state they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            ram_en_r      <= 1'b0;
            ram_we_r      <= 1'b0;
            ram_addr_r    <= {ADDR_W{1'b0}};
            ram_wdata_r   <= 8'h00;
            host_gnt_r    <= 1'b0;
            rd_src_spi_r  <= 1'b0;
            tx_data_r     <= 8'h00;
            tx_valid_r    <= 1'b0;
            host_rdata_r  <= 8'h00;
            host_rvalid_r <= 1'b0;
        end else begin
            ram_en_r      <= 1'b0;
            ram_we_r      <= 1'b0;
            ram_addr_r    <= {ADDR_W{1'b0}};
            ram_wdata_r   <= 8'h00;
            host_gnt_r    <= 1'b0;
            tx_valid_r    <= 1'b0;
            host_rvalid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (gnt_spi_s) begin
                        state_r     <= ST_SPI_ACC;
                        ram_en_r    <= 1'b1;
                        ram_we_r    <= op_we_r;
                        ram_addr_r  <= op_addr_r;
                        ram_wdata_r <= op_we_r ? op_wdata_r : 8'h00;
                    end else if (gnt_host_s) begin
                        state_r     <= ST_HOST_ACC;
                        ram_en_r    <= 1'b1;
                        ram_we_r    <= host_we;
                        ram_addr_r  <= host_addr;
                        ram_wdata_r <= host_we ? host_wdata : 8'h00;
                        host_gnt_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SPI_ACC: begin
                    rd_src_spi_r <= 1'b1;
                    state_r      <= ram_we_r ? ST_IDLE : ST_RD_RESP;
                end
                ST_HOST_ACC: begin
                    rd_src_spi_r <= 1'b0;
                    state_r      <= ram_we_r ? ST_IDLE : ST_RD_RESP;
                end
                ST_RD_RESP: begin
                    if (rd_src_spi_r) begin
                        tx_data_r  <= ram_rdata;
                        tx_valid_r <= 1'b1;
                    end else begin
                        host_rdata_r  <= ram_rdata;
                        host_rvalid_r <= 1'b1;
                    end
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_data     = tx_data_r;
    assign tx_valid    = tx_valid_r;
    assign host_gnt    = host_gnt_r;
    assign host_rdata  = host_rdata_r;
    assign host_rvalid = host_rvalid_r;
    assign ram_en      = ram_en_r;
    assign ram_we      = ram_we_r;
    assign ram_addr    = ram_addr_r;
    assign ram_wdata   = ram_wdata_r;
    assign err_ovf     = err_ovf_r;

endmodule

// File: tb/tb_spi_ram_access_ctrl.sv
// Directed bench for spi_ram_access_ctrl with a behavioural 256x8 sync RAM.
module tb_spi_ram_access_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] rx_data = 10'h000;
    logic       rx_valid = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       host_req = 1'b0;
    logic       host_we = 1'b0;
    logic [7:0] host_addr = 8'h00;
    logic [7:0] host_wdata = 8'h00;
    logic       host_gnt;
    logic [7:0] host_rdata;
    logic       host_rvalid;
    logic       ram_en, ram_we;
    logic [7:0] ram_addr, ram_wdata;
    logic [7:0] ram_rdata = 8'h00;
    logic       err_ovf;
    logic       err_clr = 1'b0;

    logic [7:0] mem [0:255];
    int         n_total = 0;
    int         n_pass = 0;

    typedef struct {
        logic [9:0] word;
        int         kind;   // 0 address cmd, 1 write, 2 read
        logic [7:0] ea;
        logic [7:0] ed;
    } vec_t;
    vec_t vecs [12];

    spi_ram_access_ctrl dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rdata(host_rdata),
        .host_rvalid(host_rvalid), .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .err_ovf(err_ovf), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    end

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic spi_send(input logic [9:0] w);
        rx_data  = w;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    function automatic logic [63:0] all_outs();
        return {26'd0, tx_valid, tx_data, host_gnt, host_rdata, host_rvalid,
                ram_en, ram_we, ram_addr, ram_wdata, err_ovf};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int en_cnt, tx_cnt, tx_cyc, w;
        logic [7:0] tx_got;
        logic [17:0] k2;

        vecs[0]  = '{10'h0A5, 0, 8'h00, 8'h00};
        vecs[1]  = '{10'h13C, 1, 8'hA5, 8'h3C};
        vecs[2]  = '{10'h2A5, 0, 8'h00, 8'h00};
        vecs[3]  = '{10'h300, 2, 8'h00, 8'h3C};
        vecs[4]  = '{10'h012, 0, 8'h00, 8'h00};
        vecs[5]  = '{10'h1C3, 1, 8'h12, 8'hC3};
        vecs[6]  = '{10'h212, 0, 8'h00, 8'h00};
        vecs[7]  = '{10'h3FF, 2, 8'h00, 8'hC3};
        vecs[8]  = '{10'h000, 0, 8'h00, 8'h00};
        vecs[9]  = '{10'h1FF, 1, 8'h00, 8'hFF};
        vecs[10] = '{10'h200, 0, 8'h00, 8'h00};
        vecs[11] = '{10'h3AA, 2, 8'h00, 8'hFF};

        tick();
        check("reset_outs", all_outs(), 64'd0);
        rst = 1'b0;
        tick();
        check("idle_outs", all_outs(), 64'd0);

        // Table-driven SPI commands: writes at N+2, read data at N+4.
        for (int i = 0; i < 12; i++) begin
            en_cnt = 0; tx_cnt = 0; tx_cyc = 0; tx_got = 8'h00; k2 = 18'd0;
            spi_send(vecs[i].word);
            for (int k = 1; k <= 6; k++) begin
                if (k > 1) tick();
                if (ram_en) en_cnt++;
                if (k == 2) k2 = {ram_en, ram_we, ram_addr, ram_wdata};
                if (tx_valid) begin
                    tx_cnt++; tx_cyc = k; tx_got = tx_data;
                end
            end
            case (vecs[i].kind)
                0: begin
                    check("addr_no_ram", 64'(en_cnt), 64'd0);
                    check("addr_no_tx", 64'(tx_cnt), 64'd0);
                end
                1: begin
                    check("wr_ram_n2", 64'(k2), 64'({1'b1, 1'b1, vecs[i].ea, vecs[i].ed}));
                    check("wr_one_access", 64'(en_cnt), 64'd1);
                    check("wr_no_tx", 64'(tx_cnt), 64'd0);
                end
                default: begin
                    check("rd_tx_cycle", 64'(tx_cyc), 64'd4);
                    check("rd_tx_once", 64'(tx_cnt), 64'd1);
                    check("rd_tx_data", 64'(tx_got), 64'(vecs[i].ed));
                end
            endcase
        end

        // Round-robin contention after reset: SPI first, then host, every round.
        do_reset();
        for (int r = 0; r < 10; r++) begin
            spi_send(10'h300);
            host_req = 1'b1; host_we = (r % 2 == 0); host_addr = 8'h10; host_wdata = 8'h77;
            tick();
            check("rr_spi_first", 64'({ram_en, ram_we, host_gnt}), 64'({1'b1, 1'b0, 1'b0}));
            w = 0;
            while (w < 8 && !host_gnt) begin
                tick(); w++;
            end
            host_req = 1'b0;
            check("rr_host_wait", 64'(w), 64'd3);
            if (r % 2 == 0) begin
                check("rr_host_wr", 64'({ram_we, ram_addr, ram_wdata}), 64'({1'b1, 8'h10, 8'h77}));
                tick();
            end else begin
                check("rr_host_rd", 64'({ram_en, ram_we, ram_addr}), 64'({1'b1, 1'b0, 8'h10}));
                tick(); tick();
                check("rr_host_rdata", 64'({host_rvalid, host_rdata}), 64'({1'b1, 8'h77}));
            end
        end
        // After a lone SPI grant, the host must win the next contention.
        spi_send(10'h300);
        for (int k = 0; k < 5; k++) tick();
        spi_send(10'h300);
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h10; host_wdata = 8'h77;
        tick();
        check("rr_host_after_spi", 64'({host_gnt, ram_en}), 64'({1'b1, 1'b1}));
        host_req = 1'b0;
        tick(); tick();
        check("rr_spi_second", 64'({ram_en, ram_we, host_gnt}), 64'({1'b1, 1'b0, 1'b0}));
        for (int k = 0; k < 3; k++) tick();

        // Overflow with host held busy: second WR_DATA dropped.
        spi_send(10'h040);
        tick();
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h10; host_wdata = 8'h77;
        spi_send(10'h111);
        spi_send(10'h122);
        check("ovf_set", 64'(err_ovf), 64'd1);
        for (int k = 0; k < 8; k++) tick();
        host_req = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("ovf_first_kept", 64'(mem[8'h40]), 64'h11);
        check("ovf_sticky", 64'(err_ovf), 64'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("ovf_cleared", 64'(err_ovf), 64'd0);
        spi_send(10'h155);
        err_clr = 1'b1;
        spi_send(10'h166);
        err_clr = 1'b0;
        check("ovf_beats_clr", 64'(err_ovf), 64'd1);
        for (int k = 0; k < 5; k++) tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("ovf_cleared2", 64'(err_ovf), 64'd0);

        // Pending write keeps its captured address across a new WR_ADDR.
        spi_send(10'h050);
        tick();
        spi_send(10'h166);
        spi_send(10'h0FF);
        for (int k = 0; k < 5; k++) tick();
        check("addr_old_used", 64'(mem[8'h50]), 64'h66);
        check("addr_no_ovf", 64'(err_ovf), 64'd0);
        spi_send(10'h199);
        for (int k = 0; k < 5; k++) tick();
        check("addr_new_used", 64'(mem[8'hFF]), 64'h99);

        // Reset during RD_RESP aborts the read; rd_addr returns to 0.
        spi_send(10'h000);
        spi_send(10'h15A);
        for (int k = 0; k < 5; k++) tick();
        spi_send(10'h2A5);
        spi_send(10'h300);
        tick(); tick();
        rst = 1'b1;
        tick();
        check("rst_mid_outs", all_outs(), 64'd0);
        tick();
        rst = 1'b0;
        tx_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (tx_valid) tx_cnt++;
        end
        check("rst_no_tx", 64'(tx_cnt), 64'd0);
        check("rst_ram_kept", 64'(mem[8'hA5]), 64'h3C);
        spi_send(10'h300);
        tick();
        check("rst_rd_addr0", 64'({ram_en, ram_we, ram_addr}), 64'({1'b1, 1'b0, 8'h00}));
        tick(); tick();
        check("rst_rd_data", 64'({tx_valid, tx_data}), 64'({1'b1, 8'h5A}));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
